// File: rtl/opb_single_master_if.sv
// Bundle of the fabric command/response handshake and the OPB master-side bus
// signals for opb_single_master. Bit 0 is the MSB, following OPB numbering.
interface opb_single_master_if #(
   parameter int unsigned C_OPB_AWIDTH = 32,
   parameter int unsigned C_OPB_DWIDTH = 32
);
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic                        cmd_rnw;
   logic [0:C_OPB_AWIDTH-1]     cmd_addr;
   logic [0:C_OPB_DWIDTH/8-1]   cmd_be;
   logic [0:C_OPB_DWIDTH-1]     cmd_wdata;
   logic                        rsp_valid;
   logic [0:C_OPB_DWIDTH-1]     rsp_rdata;
   logic [1:0]                  rsp_status;

   logic                        M_request;
   logic                        OPB_MGrant;
   logic                        M_select;
   logic                        M_RNW;
   logic [0:C_OPB_AWIDTH-1]     M_ABus;
   logic [0:C_OPB_DWIDTH/8-1]   M_BE;
   logic [0:C_OPB_DWIDTH-1]     M_DBus;
   logic                        M_seqAddr;
   logic                        M_busLock;
   logic [0:C_OPB_DWIDTH-1]     OPB_DBus;
   logic                        OPB_xferAck;
   logic                        OPB_errAck;
   logic                        OPB_retry;
   logic                        OPB_toutSup;

   modport master (
      input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
      output M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock,
      input  OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup
   );

   modport slave (
      output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
      input  M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock,
      output OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup
   );
endinterface

// File: rtl/opb_single_master.sv
// Single-beat OPB master: turns one fabric command into one OPB read or write,
// handling arbitration, errAck/retry/xferAck, timeout suppression and bus timeout.
module opb_single_master #(
   parameter int unsigned C_OPB_AWIDTH = 32,
   parameter int unsigned C_OPB_DWIDTH = 32,
   parameter int unsigned C_TIMEOUT    = 16,
   parameter int unsigned C_MAX_RETRY  = 3
) (
   input logic                 OPB_Clk,
   input logic                 OPB_Rst_n,
   opb_single_master_if.master bus
);
   localparam int unsigned BEW = C_OPB_DWIDTH / 8;

   typedef enum logic [2:0] {IDLE, REQ, XFER, BACKOFF, RESP} state_e;
   typedef enum logic [1:0] {ST_OK = 2'b00, ST_ERR = 2'b01, ST_TIMEOUT = 2'b10,
                             ST_RETRY_EX = 2'b11} status_e;

   state_e                  state, state_nxt;
   logic                    rnw_q, rnw_nxt;
   logic [0:C_OPB_AWIDTH-1] addr_q, addr_nxt;
   logic [0:BEW-1]          be_q, be_nxt;
   logic [0:C_OPB_DWIDTH-1] wdata_q, wdata_nxt;
   logic [0:C_OPB_DWIDTH-1] rdata_q, rdata_nxt;
   logic [1:0]              status_q, status_nxt;
   logic [7:0]              retry_cnt, retry_nxt;
   logic [7:0]              tout_cnt, tout_nxt;
   logic                    xfer;

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state     <= IDLE;
         rnw_q     <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         status_q  <= '0;
         retry_cnt <= '0;
         tout_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         rnw_q     <= rnw_nxt;
         addr_q    <= addr_nxt;
         be_q      <= be_nxt;
         wdata_q   <= wdata_nxt;
         rdata_q   <= rdata_nxt;
         status_q  <= status_nxt;
         retry_cnt <= retry_nxt;
         tout_cnt  <= tout_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rnw_nxt    = rnw_q;
      addr_nxt   = addr_q;
      be_nxt     = be_q;
      wdata_nxt  = wdata_q;
      rdata_nxt  = rdata_q;
      status_nxt = status_q;
      retry_nxt  = retry_cnt;
      tout_nxt   = tout_cnt;
      case (state)
         IDLE: if (bus.cmd_valid) begin
            rnw_nxt   = bus.cmd_rnw;
            addr_nxt  = bus.cmd_addr;
            be_nxt    = bus.cmd_be;
            wdata_nxt = bus.cmd_wdata;
            retry_nxt = '0;
            tout_nxt  = '0;
            state_nxt = REQ;
         end
         REQ: if (bus.OPB_MGrant) state_nxt = XFER;
         XFER: begin
            if (!bus.OPB_toutSup) tout_nxt = tout_cnt + 8'd1;
            // Priority errAck > retry > xferAck > timeout; rdata only survives a good read.
            if (bus.OPB_errAck) begin
               status_nxt = ST_ERR;
               rdata_nxt  = '0;
               state_nxt  = RESP;
            end else if (bus.OPB_retry) begin
               if (retry_cnt == 8'(C_MAX_RETRY)) begin
                  status_nxt = ST_RETRY_EX;
                  rdata_nxt  = '0;
                  state_nxt  = RESP;
               end else begin
                  retry_nxt = retry_cnt + 8'd1;
                  tout_nxt  = '0;
                  state_nxt = BACKOFF;
               end
            end else if (bus.OPB_xferAck) begin
               status_nxt = ST_OK;
               rdata_nxt  = rnw_q ? bus.OPB_DBus : '0;
               state_nxt  = RESP;
            end else if (!bus.OPB_toutSup && tout_cnt == 8'(C_TIMEOUT - 1)) begin
               status_nxt = ST_TIMEOUT;
               rdata_nxt  = '0;
               state_nxt  = RESP;
            end
         end
         BACKOFF: state_nxt = REQ;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus outputs decode straight from state so reset drops them without waiting for a clock.
   assign xfer           = (state == XFER);
   assign bus.cmd_ready  = (state == IDLE);
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_status = status_q;
   assign bus.M_request  = (state == REQ);
   assign bus.M_select   = xfer;
   assign bus.M_RNW      = xfer & rnw_q;
   assign bus.M_ABus     = xfer ? addr_q : '0;
   assign bus.M_BE       = xfer ? be_q : '0;
   assign bus.M_DBus     = (xfer && !rnw_q) ? wdata_q : '0;
   assign bus.M_seqAddr  = 1'b0;
   assign bus.M_busLock  = 1'b0;
endmodule

// File: tb/tb_opb_single_master.sv
// Bench for opb_single_master: scripted and random slave behaviour per attempt,
// outcome predicted from the response rules by a per-attempt arithmetic model.
module tb_opb_single_master;
   localparam int unsigned TOUT = 16;
   localparam int unsigned MAXR = 3;
   localparam logic [1:0] S_OK = 2'b00, S_ERR = 2'b01, S_TOUT = 2'b10, S_REX = 2'b11;

   typedef enum int {K_ACK, K_ERR, K_RETRY, K_NONE, K_ACKERR, K_ACKRETRY} kind_e;

   logic OPB_Clk = 1'b0;
   logic OPB_Rst_n = 1'b0;
   always #5 OPB_Clk = ~OPB_Clk;

   opb_single_master_if #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32)) bus ();

   opb_single_master #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_TIMEOUT(TOUT),
                       .C_MAX_RETRY(MAXR)) dut (
      .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n), .bus(bus));

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   kind_e       att_kind [5];
   int          att_dly  [5];
   int          att_sup  [5];
   int          att_gnt  [5];
   logic [31:0] att_rd   [5];

   int          exp_phases;
   int          exp_cyc  [5];
   logic [1:0]  exp_status;
   logic [31:0] exp_rdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_att(input int p, input kind_e k, input int d, input int s,
                          input int g, input logic [31:0] rd);
      att_kind[p] = k; att_dly[p] = d; att_sup[p] = s; att_gnt[p] = g; att_rd[p] = rd;
   endtask

   // Each attempt ends at its response cycle or at the timeout cycle (suppressed
   // cycles do not count); retries chain attempts until the retry budget is spent.
   task automatic predict(input logic rnw);
      int limit;
      bool_loop: for (int p = 0; p < 5; p++) begin
         limit = att_sup[p] + int'(TOUT);
         exp_phases = p + 1;
         if (att_kind[p] == K_NONE || att_dly[p] > limit) begin
            exp_cyc[p] = limit; exp_status = S_TOUT; exp_rdata = '0;
            break;
         end
         exp_cyc[p] = att_dly[p];
         if (att_kind[p] == K_ERR || att_kind[p] == K_ACKERR) begin
            exp_status = S_ERR; exp_rdata = '0;
            break;
         end else if (att_kind[p] == K_RETRY || att_kind[p] == K_ACKRETRY) begin
            if (p == int'(MAXR)) begin
               exp_status = S_REX; exp_rdata = '0;
               break;
            end
         end else begin
            exp_status = S_OK; exp_rdata = rnw ? att_rd[p] : 32'h0;
            break;
         end
      end
   endtask

   task automatic idle_bus_checks(input string where);
      check_eq({where, "_select"}, 32'(bus.M_select), 32'h0);
      check_eq({where, "_abus"},   bus.M_ABus, 32'h0);
      check_eq({where, "_dbus"},   bus.M_DBus, 32'h0);
      check_eq({where, "_be_rnw"}, {27'h0, bus.M_BE, bus.M_RNW}, 32'h0);
   endtask

   // Called at a negedge in IDLE; returns at a negedge back in IDLE.
   task automatic run_txn(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
      int c;
      bit ack, err, rty;
      predict(rnw);
      check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'h1);
      bus.cmd_valid = 1'b1; bus.cmd_rnw = rnw; bus.cmd_addr = addr;
      bus.cmd_be = be; bus.cmd_wdata = wdata;
      @(negedge OPB_Clk);
      bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
      check_eq("cmd_ready_busy", 32'(bus.cmd_ready), 32'h0);
      for (int p = 0; p < exp_phases; p++) begin
         for (int k = 0; k <= att_gnt[p]; k++) begin
            check_eq("request", 32'(bus.M_request), 32'h1);
            idle_bus_checks("req");
            bus.OPB_MGrant = (k == att_gnt[p]);
            @(negedge OPB_Clk);
         end
         bus.OPB_MGrant = 1'b0;
         c = 0;
         while (bus.M_select && c < 300) begin
            c++;
            check_eq("xfer_request", 32'(bus.M_request), 32'h0);
            check_eq("xfer_abus", bus.M_ABus, addr);
            check_eq("xfer_be_rnw", {27'h0, bus.M_BE, bus.M_RNW}, {27'h0, be, rnw});
            check_eq("xfer_dbus", bus.M_DBus, rnw ? 32'h0 : wdata);
            ack = (c == att_dly[p]) && (att_kind[p] inside {K_ACK, K_ACKERR, K_ACKRETRY});
            err = (c == att_dly[p]) && (att_kind[p] inside {K_ERR, K_ACKERR});
            rty = (c == att_dly[p]) && (att_kind[p] inside {K_RETRY, K_ACKRETRY});
            bus.OPB_xferAck = ack; bus.OPB_errAck = err; bus.OPB_retry = rty;
            bus.OPB_toutSup = (c <= att_sup[p]);
            bus.OPB_DBus = ack ? att_rd[p] : $urandom;
            @(negedge OPB_Clk);
            bus.OPB_xferAck = 1'b0; bus.OPB_errAck = 1'b0; bus.OPB_retry = 1'b0;
            bus.OPB_toutSup = 1'b0; bus.OPB_DBus = '0;
         end
         check_eq("select_cycles", 32'(c), 32'(exp_cyc[p]));
         if (p < exp_phases - 1) begin
            check_eq("backoff_req_rsp", {30'h0, bus.M_request, bus.rsp_valid}, 32'h0);
            idle_bus_checks("backoff");
            @(negedge OPB_Clk);
         end
      end
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check_eq("rsp_status", 32'(bus.rsp_status), 32'(exp_status));
      check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
      idle_bus_checks("resp");
      @(negedge OPB_Clk);
      check_eq("rsp_pulse_end", 32'(bus.rsp_valid), 32'h0);
      check_eq("cmd_ready_after", 32'(bus.cmd_ready), 32'h1);
      check_eq("rsp_status_hold", 32'(bus.rsp_status), 32'(exp_status));
      check_eq("rsp_rdata_hold", bus.rsp_rdata, exp_rdata);
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_addr = '0; bus.cmd_be = '0;
      bus.cmd_wdata = '0; bus.OPB_MGrant = 1'b0; bus.OPB_DBus = '0;
      bus.OPB_xferAck = 1'b0; bus.OPB_errAck = 1'b0; bus.OPB_retry = 1'b0;
      bus.OPB_toutSup = 1'b0;
      for (int p = 0; p < 5; p++) set_att(p, K_ACK, 1, 0, 0, 32'h0);

      repeat (2) @(negedge OPB_Clk);
      check_eq("reset_cmd_ready", 32'(bus.cmd_ready), 32'h1);
      check_eq("reset_req_rsp", {30'h0, bus.M_request, bus.rsp_valid}, 32'h0);
      check_eq("reset_status_rdata", {bus.rsp_status, 30'h0} | bus.rsp_rdata, 32'h0);
      check_eq("reset_tied", {30'h0, bus.M_seqAddr, bus.M_busLock}, 32'h0);
      idle_bus_checks("reset");
      OPB_Rst_n = 1'b1;
      @(negedge OPB_Clk);

      set_att(0, K_ACK, 2, 0, 0, 32'h0);
      run_txn(1'b0, 32'h01040400, 4'hF, 32'hDEADBEEF);
      set_att(0, K_ACK, 1, 0, 0, 32'h12345678);
      run_txn(1'b1, 32'h00000010, 4'hF, 32'hFFFFFFFF);
      set_att(0, K_ACK, 1, 0, 5, 32'hCAFE0001);
      run_txn(1'b1, 32'h00000020, 4'h3, 32'h0);
      set_att(0, K_NONE, 1, 0, 0, 32'h0);
      run_txn(1'b1, 32'h00000030, 4'hF, 32'h0);
      set_att(0, K_NONE, 1, 10, 0, 32'h0);
      run_txn(1'b0, 32'h00000034, 4'hF, 32'h55AA55AA);
      for (int p = 0; p < 5; p++) set_att(p, K_RETRY, 1 + p, 0, p % 2, 32'h0);
      run_txn(1'b1, 32'h00000040, 4'hF, 32'h0);
      set_att(0, K_RETRY, 2, 0, 0, 32'h0);
      set_att(1, K_ERR, 1, 0, 1, 32'h0);
      run_txn(1'b0, 32'h00000044, 4'hC, 32'h11223344);
      set_att(0, K_ACKERR, 1, 0, 0, 32'h87654321);
      run_txn(1'b1, 32'h00000048, 4'hF, 32'h0);
      set_att(0, K_ACK, 16, 0, 0, 32'hA5A5A5A5);
      run_txn(1'b1, 32'h0000004C, 4'hF, 32'h0);

      for (int t = 0; t < 40; t++) begin
         for (int p = 0; p < 5; p++) begin
            kind_e k;
            case ($urandom_range(0, 9))
               0, 1, 2: k = K_ACK;
               3:       k = K_ERR;
               4, 5, 6: k = K_RETRY;
               7:       k = K_NONE;
               8:       k = K_ACKERR;
               default: k = K_ACKRETRY;
            endcase
            set_att(p, k, int'($urandom_range(1, 5)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), $urandom);
         end
         run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom);
      end

      bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b0; bus.cmd_addr = 32'h100;
      bus.cmd_be = 4'hF; bus.cmd_wdata = 32'h0BADF00D;
      @(negedge OPB_Clk);
      bus.cmd_valid = 1'b0; bus.OPB_MGrant = 1'b1;
      @(negedge OPB_Clk);
      bus.OPB_MGrant = 1'b0;
      check_eq("pre_reset_select", 32'(bus.M_select), 32'h1);
      OPB_Rst_n = 1'b0;
      #1;
      check_eq("async_reset_sel_req", {30'h0, bus.M_select, bus.M_request}, 32'h0);
      check_eq("async_reset_ready", 32'(bus.cmd_ready), 32'h1);
      idle_bus_checks("async_reset");
      @(negedge OPB_Clk);
      OPB_Rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge OPB_Clk);
         check_eq("post_reset_no_rsp", 32'(bus.rsp_valid), 32'h0);
         check_eq("post_reset_ready", 32'(bus.cmd_ready), 32'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/opb_single_master.md
# opb_single_master

Single-beat OPB bus master that turns a simple valid/ready command from fabric logic into one OPB read or write. It handles arbitration, xferAck, errAck, retry, timeout suppression and bus timeout, then returns read data and a status code. It is the initiator counterpart to the `opb_register_*` slaves and sits between user logic and the OPB arbiter/bus in the XPS base system.

## Interface
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width.
- C_TIMEOUT, 16: select cycles without a slave response before abort; legal range 2..255.
- C_MAX_RETRY, 3: retries allowed before the command fails; 0 means the first retry fails it.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  [0:31]  byte address.
- cmd_be  in  [0:3]  byte enables.
- cmd_wdata  in  [0:31]  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  [0:31]  read data; zero for writes and failures.
- rsp_status  out  2  00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED.
- M_request  out  1  bus request to arbiter.
- OPB_MGrant  in  1  arbiter grant.
- M_select  out  1  transfer in progress.
- M_RNW  out  1  direction.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- M_seqAddr  out  1  tied 0.
- M_busLock  out  1  tied 0.
- OPB_DBus  in  [0:31]  OR-ed bus read data.
- OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup  in  1 each  slave responses.

## Operation
- States: IDLE, REQ, XFER, BACKOFF, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch rnw/addr/be/wdata, clear retry and timeout counters, go to REQ.
- REQ: M_request=1. OPB_MGrant high goes to XFER.
- XFER: M_select=1, M_request=0. M_ABus, M_BE and M_RNW carry the latched values. M_DBus carries wdata on writes and zero on reads.
  - Timeout counter increments each XFER cycle unless OPB_toutSup=1 (held, not cleared).
  - Response priority in the same cycle: errAck > retry > xferAck > timeout.
  - errAck: status ERR, go to RESP.
  - xferAck: status OK; on reads, capture OPB_DBus into rsp_rdata; go to RESP.
  - retry: if retry count = C_MAX_RETRY, status RETRY_EXHAUSTED and go to RESP. Otherwise increment the count, clear the timeout counter and go to BACKOFF.
  - timeout: counter reaching C_TIMEOUT with no response sets status TIMEOUT and goes to RESP.
- BACKOFF: all M_* deasserted for exactly 1 cycle, then REQ.
- RESP: rsp_valid=1 for one cycle, then IDLE. The response has no backpressure. rsp_rdata and rsp_status hold until the next RESP.
- Outside XFER, M_ABus, M_BE, M_DBus and M_RNW are all zero, as the OR-bus requires.
- Reset (asynchronous): state IDLE. All outputs 0 except cmd_ready, which is 1. Counters 0. Reset mid-transaction drops M_select/M_request immediately with no response.

## Timing
- Command accepted at edge N; M_request is high in cycle N+1.
- Grant sampled high at edge G; M_select is high from G+1.
- Response sampled at edge A; M_select is low in A+1 and rsp_valid is high in A+1.
- Minimum latency, with grant present in the first REQ cycle and xferAck in the first XFER cycle: accept to rsp_valid = 3 cycles.
- Next cmd_ready comes 1 cycle after rsp_valid.
- Timeout: with no toutSup, TIMEOUT is declared after C_TIMEOUT XFER cycles, and rsp_valid follows 1 cycle later.
- Each retry adds 1 BACKOFF cycle plus re-arbitration.

## Test plan
- Write addr 0x01040400, data 0xDEADBEEF, BE 1111, grant immediate, xferAck on the 2nd select cycle -> M_DBus=0xDEADBEEF only while select is high; rsp_status=00, rsp_rdata=0.
- Read with OPB_DBus=0x12345678 at xferAck -> rsp_rdata=0x12345678, status 00; M_DBus is 0 throughout.
- Grant withheld 5 cycles -> M_request held 5 cycles, M_select never asserted before grant.
- No response, C_TIMEOUT=16 -> exactly 16 select cycles, status 10. Repeat with toutSup held high 10 cycles -> 26 select cycles.
- Retry on every attempt, C_MAX_RETRY=3 -> 4 select phases with 1-cycle gaps, status 11. Retry then errAck -> status 01. Same-cycle xferAck+errAck -> status 01.
- Async reset asserted mid-XFER -> M_select/M_request fall immediately, cmd_ready=1 after release, no rsp_valid.
